ipr_mfifo: RTL and testbench

Parametrised multi-channel inter-processor FIFO. It gives cores on the grid NCHAN independent mailboxes, each DEPTH words of DATA_W bits. Access is through the LSU-style req/gnt/rvalid read and write ports, with per-channel status, flush and doorbell outputs. It replaces the single-queue IPR FIFO, adding channel select, non-power-of-two depth, a non-blocking error mode and almost-full signalling.

---
 rtl/ipr_mfifo_pkg.sv | 27 ++
 rtl/ipr_mfifo_chan.sv | 83 ++++++++
 rtl/ipr_mfifo.sv | 151 +++++++++++++++
 tb/tb_ipr_mfifo.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipr_mfifo_pkg.sv
// Shared sizing helpers and types for the multi-channel inter-processor FIFO.
package ipr_mfifo_pkg;

    // Widest per-channel occupancy carried in the status struct.
    localparam int CNT_MAX_W = 16;

    function automatic int chan_w(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [CNT_MAX_W-1:0] count;
        logic                 empty;
        logic                 full;
        logic                 afull;
    } chan_status_t;

    typedef enum logic {
        RESP_OK  = 1'b0,
        RESP_ERR = 1'b1
    } resp_e;

endpackage

// File: rtl/ipr_mfifo_chan.sv
// One mailbox channel: circular buffer storage, pointers, occupancy, flags and doorbell.
module ipr_mfifo_chan
    import ipr_mfifo_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 50,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int PW       = $clog2(DEPTH),
    localparam int CNTW     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_rdata,
    output chan_status_t      o_status,
    output logic              o_doorbell
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW-1:0]     w_wptr_nxt;
    logic [PW-1:0]     w_rptr_nxt;
    logic [CNTW-1:0]   r_count;
    logic [CNTW-1:0]   w_count_nxt;
    logic              r_doorbell;
    logic              w_empty;

    assign w_empty    = (r_count == '0);
    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_comb begin
        w_count_nxt = r_count;
        if (i_wr && !i_rd) begin
            w_count_nxt = r_count + 1'b1;
        end else if (i_rd && !i_wr) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_doorbell <= 1'b0;
        end else if (i_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_doorbell <= 1'b0;
        end else begin
            if (i_wr) begin
                r_wptr <= w_wptr_nxt;
            end
            if (i_rd) begin
                r_rptr <= w_rptr_nxt;
            end
            r_count    <= w_count_nxt;
            // A read is never accepted on an empty channel, so any write here fills it.
            r_doorbell <= w_empty & i_wr;
        end
    end

    assign o_rdata        = r_mem[r_rptr];
    assign o_status.count = CNT_MAX_W'(r_count);
    assign o_status.empty = w_empty;
    assign o_status.full  = (r_count == CNTW'(DEPTH));
    assign o_status.afull = (r_count >= CNTW'(AF_LEVEL));
    assign o_doorbell     = r_doorbell;

endmodule

// File: rtl/ipr_mfifo.sv
// Multi-channel inter-processor FIFO: port decode, channel array, read-data mux and responses.
module ipr_mfifo
    import ipr_mfifo_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 50,
    parameter  int NCHAN    = 4,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int BLOCKING = 1,
    localparam int CW       = chan_w(NCHAN),
    localparam int CNTW     = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  wr_we,
    input  logic [CW-1:0]         wr_chan,
    input  logic [DATA_W-1:0]     wr_wdata,
    output logic                  wr_gnt,
    output logic                  wr_rvalid,
    output logic                  wr_err,
    input  logic                  rd_req,
    input  logic [CW-1:0]         rd_chan,
    output logic                  rd_gnt,
    output logic                  rd_rvalid,
    output logic [DATA_W-1:0]     rd_rdata,
    output logic                  rd_err,
    input  logic [NCHAN-1:0]      flush,
    output logic [NCHAN*CNTW-1:0] count,
    output logic [NCHAN-1:0]      empty,
    output logic [NCHAN-1:0]      full,
    output logic [NCHAN-1:0]      afull,
    output logic [NCHAN-1:0]      doorbell
);

    localparam logic NB = (BLOCKING == 0);

    chan_status_t      w_status   [NCHAN];
    logic [DATA_W-1:0] w_ch_rdata [NCHAN];
    logic [NCHAN-1:0]  w_wr_en;
    logic [NCHAN-1:0]  w_rd_en;
    logic              w_wr_full;
    logic              w_wr_flush;
    logic              w_rd_empty;
    logic              w_rd_flush;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_wr_can;
    logic              w_rd_can;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_unused_cnt;

    logic              r_wr_rvalid;
    resp_e             r_wr_resp;
    logic              r_rd_rvalid;
    resp_e             r_rd_resp;
    logic [DATA_W-1:0] r_rd_rdata;

    // Out-of-range channels match no entry and keep full/empty asserted, so they are never accepted.
    always_comb begin
        w_wr_full  = 1'b1;
        w_wr_flush = 1'b0;
        w_rd_empty = 1'b1;
        w_rd_flush = 1'b0;
        w_rd_word  = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (wr_chan == CW'(i)) begin
                w_wr_full  = w_status[i].full;
                w_wr_flush = flush[i];
            end
            if (rd_chan == CW'(i)) begin
                w_rd_empty = w_status[i].empty;
                w_rd_flush = flush[i];
                w_rd_word  = w_ch_rdata[i];
            end
        end
    end

    assign w_wr_can = wr_req & wr_we & ~w_wr_full;
    assign w_rd_can = rd_req & ~w_rd_empty;
    assign w_wr_acc = w_wr_can & ~w_wr_flush;
    assign w_rd_acc = w_rd_can & ~w_rd_flush;

    generate
        if (BLOCKING != 0) begin : g_blocking
            assign wr_gnt = w_wr_can & ~rst;
            assign rd_gnt = w_rd_can & ~rst;
        end else begin : g_nonblocking
            assign wr_gnt = wr_req & wr_we & ~rst;
            assign rd_gnt = rd_req & ~rst;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NCHAN; i++) begin : g_chan
            assign w_wr_en[i] = w_wr_acc & (wr_chan == CW'(i));
            assign w_rd_en[i] = w_rd_acc & (rd_chan == CW'(i));

            ipr_mfifo_chan #(
                .DATA_W   (DATA_W),
                .DEPTH    (DEPTH),
                .AF_LEVEL (AF_LEVEL)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .i_wr       (w_wr_en[i]),
                .i_wdata    (wr_wdata),
                .i_rd       (w_rd_en[i]),
                .i_flush    (flush[i]),
                .o_rdata    (w_ch_rdata[i]),
                .o_status   (w_status[i]),
                .o_doorbell (doorbell[i])
            );

            assign count[i*CNTW +: CNTW] = w_status[i].count[CNTW-1:0];
            assign empty[i]              = w_status[i].empty;
            assign full[i]               = w_status[i].full;
            assign afull[i]              = w_status[i].afull;
        end
    endgenerate

    always_comb begin
        w_unused_cnt = 1'b0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            w_unused_cnt = w_unused_cnt ^ (|(w_status[i].count >> CNTW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_rvalid <= 1'b0;
            r_wr_resp   <= RESP_OK;
            r_rd_rvalid <= 1'b0;
            r_rd_resp   <= RESP_OK;
            r_rd_rdata  <= '0;
        end else begin
            r_wr_rvalid <= wr_gnt;
            r_wr_resp   <= (NB && wr_gnt && !w_wr_acc) ? RESP_ERR : RESP_OK;
            r_rd_rvalid <= rd_gnt;
            r_rd_resp   <= (NB && rd_gnt && !w_rd_acc) ? RESP_ERR : RESP_OK;
            r_rd_rdata  <= w_rd_acc ? w_rd_word : '0;
        end
    end

    assign wr_rvalid = r_wr_rvalid;
    assign wr_err    = (r_wr_resp == RESP_ERR);
    assign rd_rvalid = r_rd_rvalid;
    assign rd_err    = (r_rd_resp == RESP_ERR);
    assign rd_rdata  = r_rd_rdata;

endmodule

// File: tb/tb_ipr_mfifo.sv
// Bench for ipr_mfifo: blocking and non-blocking instances share stimulus, checked against per-channel queues.
module tb_ipr_mfifo;

    localparam int DW   = 32;
    localparam int DEP  = 50;
    localparam int NCH  = 5;
    localparam int CW   = 3;
    localparam int CNTW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_req = 1'b0;
    logic           wr_we = 1'b0;
    logic [CW-1:0]  wr_chan = '0;
    logic [DW-1:0]  wr_wdata = '0;
    logic           rd_req = 1'b0;
    logic [CW-1:0]  rd_chan = '0;
    logic [NCH-1:0] flush = '0;

    logic [1:0]                     wr_gnt_o, wr_rvalid_o, wr_err_o;
    logic [1:0]                     rd_gnt_o, rd_rvalid_o, rd_err_o;
    logic [1:0][DW-1:0]             rd_rdata_o;
    logic [1:0][NCH*CNTW-1:0]       count_o;
    logic [1:0][NCH-1:0]            empty_o, full_o, afull_o, doorbell_o;

    int checks   = 0;
    int failures = 0;

    // Reference: one queue per instance per channel; index 0 is blocking, 1 non-blocking.
    bit [DW-1:0]         q [2][NCH][$];
    logic [1:0]          e_wrv = '0, e_wre = '0, e_rdv = '0, e_rde = '0, e_rdchk = '0;
    logic [1:0][DW-1:0]  e_rdd = '0;
    logic [1:0][NCH-1:0] e_db = '0;

    always #5 clk = ~clk;

    ipr_mfifo #(
        .DATA_W(DW), .DEPTH(DEP), .NCHAN(NCH), .AF_LEVEL(DEP - 2), .BLOCKING(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_we(wr_we), .wr_chan(wr_chan), .wr_wdata(wr_wdata),
        .wr_gnt(wr_gnt_o[0]), .wr_rvalid(wr_rvalid_o[0]), .wr_err(wr_err_o[0]),
        .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_gnt(rd_gnt_o[0]), .rd_rvalid(rd_rvalid_o[0]), .rd_rdata(rd_rdata_o[0]), .rd_err(rd_err_o[0]),
        .flush(flush), .count(count_o[0]), .empty(empty_o[0]), .full(full_o[0]),
        .afull(afull_o[0]), .doorbell(doorbell_o[0])
    );

    ipr_mfifo #(
        .DATA_W(DW), .DEPTH(DEP), .NCHAN(NCH), .AF_LEVEL(DEP - 2), .BLOCKING(0)
    ) dut_n (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_we(wr_we), .wr_chan(wr_chan), .wr_wdata(wr_wdata),
        .wr_gnt(wr_gnt_o[1]), .wr_rvalid(wr_rvalid_o[1]), .wr_err(wr_err_o[1]),
        .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_gnt(rd_gnt_o[1]), .rd_rvalid(rd_rvalid_o[1]), .rd_rdata(rd_rdata_o[1]), .rd_err(rd_err_o[1]),
        .flush(flush), .count(count_o[1]), .empty(empty_o[1]), .full(full_o[1]),
        .afull(afull_o[1]), .doorbell(doorbell_o[1])
    );

    task automatic chk(input string name, input int b, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", name, b, act, exp);
        end
    endtask

    function automatic logic [CNTW-1:0] cnt(input int b, input int c);
        return count_o[b][c*CNTW +: CNTW];
    endfunction

    // Called once per cycle at the falling edge: compare, then advance the reference.
    task automatic model_step();
        for (int b = 0; b < 2; b++) begin
            bit                  blk, wreq, win, rin, wcan, rcan, wacc, racc, wg, rg;
            logic [NCH*CNTW-1:0] ec;
            logic [NCH-1:0]      ee, ef, ea, was_empty;
            blk = (b == 0);
            if (rst) begin
                chk("rst_wr_gnt", b, wr_gnt_o[b], 0);
                chk("rst_rd_gnt", b, rd_gnt_o[b], 0);
                chk("rst_rvalid", b, {wr_rvalid_o[b], rd_rvalid_o[b]}, 0);
                chk("rst_err", b, {wr_err_o[b], rd_err_o[b]}, 0);
                chk("rst_rdata", b, rd_rdata_o[b], 0);
                chk("rst_count", b, count_o[b], 0);
                chk("rst_empty", b, empty_o[b], {NCH{1'b1}});
                chk("rst_flags", b, {full_o[b], afull_o[b], doorbell_o[b]}, 0);
                for (int c = 0; c < NCH; c++) q[b][c].delete();
                e_wrv[b] = 0; e_wre[b] = 0; e_rdv[b] = 0; e_rde[b] = 0; e_rdchk[b] = 0;
                e_rdd[b] = '0; e_db[b] = '0;
                continue;
            end
            chk("wr_rvalid", b, wr_rvalid_o[b], e_wrv[b]);
            chk("wr_err", b, wr_err_o[b], e_wre[b]);
            chk("rd_rvalid", b, rd_rvalid_o[b], e_rdv[b]);
            chk("rd_err", b, rd_err_o[b], e_rde[b]);
            if (e_rdchk[b]) chk("rd_rdata", b, rd_rdata_o[b], e_rdd[b]);
            for (int c = 0; c < NCH; c++) begin
                ec[c*CNTW +: CNTW] = CNTW'(q[b][c].size());
                ee[c] = (q[b][c].size() == 0);
                ef[c] = (q[b][c].size() == DEP);
                ea[c] = (q[b][c].size() >= DEP - 2);
                was_empty[c] = ee[c];
            end
            chk("count", b, count_o[b], ec);
            chk("empty", b, empty_o[b], ee);
            chk("full", b, full_o[b], ef);
            chk("afull", b, afull_o[b], ea);
            chk("doorbell", b, doorbell_o[b], e_db[b]);

            win  = int'(wr_chan) < NCH;
            rin  = int'(rd_chan) < NCH;
            wreq = wr_req && wr_we;
            wcan = wreq && win && (q[b][wr_chan].size() < DEP);
            rcan = rd_req && rin && (q[b][rd_chan].size() > 0);
            wacc = wcan && !flush[wr_chan];
            racc = rcan && !flush[rd_chan];
            wg   = blk ? wcan : wreq;
            rg   = blk ? rcan : rd_req;
            chk("wr_gnt", b, wr_gnt_o[b], wg);
            chk("rd_gnt", b, rd_gnt_o[b], rg);

            e_wrv[b]   = wg;
            e_wre[b]   = !blk && wg && !wacc;
            e_rdv[b]   = rg;
            e_rde[b]   = !blk && rg && !racc;
            e_rdchk[b] = rg && (racc || !blk);
            e_rdd[b]   = racc ? q[b][rd_chan][0] : '0;
            if (racc) void'(q[b][rd_chan].pop_front());
            if (wacc) q[b][wr_chan].push_back(wr_wdata);
            for (int c = 0; c < NCH; c++) begin
                if (flush[c]) q[b][c].delete();
                e_db[b][c] = was_empty[c] && (q[b][c].size() > 0);
            end
        end
    endtask

    task automatic idle();
        wr_req = 0; wr_we = 0; rd_req = 0; flush = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        wr_req = 1; wr_we = 1; wr_chan = CW'(ch); wr_wdata = DW'(d);
    endtask

    task automatic rd(input int ch);
        rd_req = 1; rd_chan = CW'(ch);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rvcnt;
        int wp, rp;
        idle();
        rst = 1;
        repeat (2) cyc();
        rst = 0;
        chk("lit_reset_empty", 0, empty_o[0], 5'h1f);

        // Fill ch0 to exactly DEPTH, then probe the 51st write.
        for (int i = 0; i < DEP; i++) begin wr(0, i); cyc(); end
        chk("lit_full0", 0, full_o[0][0], 1);
        chk("lit_count0_50", 1, cnt(1, 0), 50);
        wr(0, 50); #1;
        chk("lit_blk_51_gnt", 0, wr_gnt_o[0], 0);
        chk("lit_nb_51_gnt", 1, wr_gnt_o[1], 1);
        cyc();
        chk("lit_nb_51_err", 1, wr_err_o[1], 1);
        rd(0); #1;
        chk("lit_blk_rd_full", 0, rd_gnt_o[0], 1);
        chk("lit_blk_wr_held", 0, wr_gnt_o[0], 0);
        cyc();
        chk("lit_first_rd", 0, rd_rdata_o[0], 0);
        rd_req = 0; #1;
        chk("lit_blk_51_late", 0, wr_gnt_o[0], 1);
        cyc();
        idle();
        for (int i = 1; i <= DEP; i++) begin
            rd(0); cyc();
            chk("lit_drain", 0, rd_rdata_o[0], i);
            chk("lit_drain", 1, rd_rdata_o[1], i);
        end
        idle(); cyc();

        // Independent channels and doorbells.
        wr(1, 'hA); cyc();
        chk("lit_db1", 0, doorbell_o[0], 5'b00010);
        wr(2, 'hB); cyc();
        chk("lit_db2", 1, doorbell_o[1], 5'b00100);
        idle(); rd(2); cyc();
        chk("lit_rd_ch2", 0, rd_rdata_o[0], 'hB);
        rd(1); cyc();
        chk("lit_rd_ch1", 1, rd_rdata_o[1], 'hA);
        chk("lit_db_quiet", 0, doorbell_o[0], 0);

        // Empty-channel read.
        idle(); rd(3); #1;
        chk("lit_blk_rd_empty_gnt", 0, rd_gnt_o[0], 0);
        chk("lit_nb_rd_empty_gnt", 1, rd_gnt_o[1], 1);
        cyc();
        chk("lit_nb_rd_empty_resp", 1, {rd_rvalid_o[1], rd_err_o[1]}, 2'b11);
        chk("lit_nb_rd_empty_data", 1, rd_rdata_o[1], 0);
        chk("lit_nb_cnt3", 1, cnt(1, 3), 0);

        // Write to full channel must not overwrite.
        idle();
        for (int i = 0; i < DEP; i++) begin wr(0, 100 + i); cyc(); end
        wr(0, 'hDEAD); cyc();
        chk("lit_nb_full_err", 1, wr_err_o[1], 1);
        idle();
        for (int i = 0; i < DEP; i++) begin
            rd(0); cyc();
            chk("lit_full_drain", 1, rd_rdata_o[1], 100 + i);
        end

        // Simultaneous read and write on one channel.
        idle(); wr(0, 'h11); cyc();
        idle(); wr(0, 'h22); rd(0); cyc();
        chk("lit_rw_count", 0, cnt(0, 0), 1);
        chk("lit_rw_data", 0, rd_rdata_o[0], 'h11);
        idle(); rd(0); cyc();
        idle(); wr(0, 'h33); rd(0); #1;
        chk("lit_rw_empty_gnt", 0, rd_gnt_o[0], 0);
        cyc();
        chk("lit_rw_empty_cnt", 1, cnt(1, 0), 1);
        chk("lit_rw_empty_err", 1, rd_err_o[1], 1);
        idle(); rd(0); cyc();

        // Flush against a same-cycle write.
        idle();
        for (int i = 0; i < 20; i++) begin wr(0, 200 + i); cyc(); end
        chk("lit_cnt20", 0, cnt(0, 0), 20);
        wr(0, 'h77); flush = 5'b00001; #1;
        chk("lit_flush_gnt", 0, wr_gnt_o[0], 1);
        cyc();
        chk("lit_flush_cnt", 0, cnt(0, 0), 0);
        chk("lit_flush_empty", 1, empty_o[1][0], 1);
        chk("lit_flush_nb_err", 1, wr_err_o[1], 1);
        chk("lit_flush_blk_resp", 0, {wr_rvalid_o[0], wr_err_o[0]}, 2'b10);

        // Out-of-range channel.
        idle(); wr(6, 'h5); rd(7); #1;
        chk("lit_oor_blk_gnt", 0, {wr_gnt_o[0], rd_gnt_o[0]}, 0);
        chk("lit_oor_nb_gnt", 1, {wr_gnt_o[1], rd_gnt_o[1]}, 2'b11);
        cyc();
        chk("lit_oor_nb_err", 1, {wr_err_o[1], rd_err_o[1]}, 2'b11);

        // Randomized traffic: a filling phase then a draining phase.
        for (int n = 0; n < 3000; n++) begin
            wp = (n < 1500) ? 80 : 30;
            rp = (n < 1500) ? 25 : 70;
            wr_req   = ($urandom_range(0, 99) < wp);
            wr_we    = ($urandom_range(0, 9) != 0);
            wr_chan  = CW'($urandom_range(0, 5));
            wr_wdata = $urandom();
            rd_req   = ($urandom_range(0, 99) < rp);
            rd_chan  = CW'($urandom_range(0, 5));
            flush    = ($urandom_range(0, 255) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
            cyc();
        end

        // Back-to-back reads, then reset with a response in flight.
        idle(); flush = '1; cyc(); idle();
        for (int i = 0; i < 8; i++) begin wr(4, 300 + i); cyc(); end
        idle();
        rvcnt = 0;
        for (int i = 0; i < 4; i++) begin
            rd(4); cyc();
            if (rd_rvalid_o[0] && rd_rvalid_o[1]) rvcnt++;
        end
        chk("lit_b2b_rvalids", 0, rvcnt, 4);
        rd(4); cyc();
        rst = 1; #1;
        chk("lit_midrst_rvalid", 0, {rd_rvalid_o[0], rd_rvalid_o[1]}, 0);
        chk("lit_midrst_count", 1, cnt(1, 4), 0);
        chk("lit_midrst_empty", 0, empty_o[0], 5'h1f);
        cyc();
        rst = 0; idle();
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
